grid6_coloring_search: RTL

Sequential search engine that enumerates all 64 two-colorings of the 6-vertex 2x3 grid graph, checks each one, and streams every proper coloring out through a valid/ready port. The graph has vertices 0-1-2 / 3-4-5 and edges (0,1),(0,3),(1,2),(1,4),(2,5),(3,4),(4,5). The block sits above the combinational grid edge checker and sequences candidate colorings through it. Optional per-vertex pins restrict the search space.

---
 rtl/grid6_pkg.sv | 32 +++
 rtl/grid6_edge_check.sv | 16 +
 rtl/grid6_coloring_search.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/grid6_pkg.sv
// Shared constants and types for the 2x3 grid two-colouring search engine.
package grid6_pkg;

  localparam int NV        = 6;
  localparam int NUM_EDGES = 7;
  localparam int CNT_W     = 7;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
  } edge_t;

  // Grid 0-1-2 / 3-4-5
  localparam edge_t EDGES [NUM_EDGES] = '{
    '{a: 3'd0, b: 3'd1},
    '{a: 3'd0, b: 3'd3},
    '{a: 3'd1, b: 3'd2},
    '{a: 3'd1, b: 3'd4},
    '{a: 3'd2, b: 3'd5},
    '{a: 3'd3, b: 3'd4},
    '{a: 3'd4, b: 3'd5}
  };

  localparam logic [NV-1:0] LAST_CAND = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    FOUND  = 2'd2
  } search_state_t;

endpackage

// File: rtl/grid6_edge_check.sv
// Combinational check that a two-colouring is proper on every grid edge.
module grid6_edge_check
  import grid6_pkg::*;
(
  input  logic [NV-1:0] c_i,
  output logic          ok_o
);

  always_comb begin
    ok_o = 1'b1;
    for (int i = 0; i < NUM_EDGES; i++) begin
      ok_o = ok_o & (c_i[EDGES[i].a] ^ c_i[EDGES[i].b]);
    end
  end

endmodule

// File: rtl/grid6_coloring_search.sv
// Walks candidates 0..63 through the edge checker and streams proper colourings.
// state  | meaning
// IDLE   | waiting for start; pins and count hold last search
// SEARCH | evaluating one candidate per cycle
// FOUND  | sol_valid high, waiting for sol_ready
module grid6_coloring_search
  import grid6_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [NV-1:0]    pin_en_i,
  input  logic [NV-1:0]    pin_val_i,
  output logic             busy_o,
  output logic             sol_valid_o,
  input  logic             sol_ready_i,
  output logic [NV-1:0]    sol_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sol_cnt_o
);

  search_state_t    state_q, state_d;
  logic [NV-1:0]    cand_q, cand_d;
  logic [NV-1:0]    pin_en_q, pin_en_d;
  logic [NV-1:0]    pin_val_q, pin_val_d;
  logic [NV-1:0]    sol_q, sol_d;
  logic             sol_valid_q, sol_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             edge_ok;
  logic             cand_ok;
  logic             handshake;
  logic             last_cand;

  grid6_edge_check u_edge_check (
    .c_i  (cand_q),
    .ok_o (edge_ok)
  );

  assign cand_ok   = edge_ok && (((cand_q ^ pin_val_q) & pin_en_q) == '0);
  assign handshake = sol_valid_q && sol_ready_i;
  assign last_cand = (cand_q == LAST_CAND);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      pin_en_q    <= '0;
      pin_val_q   <= '0;
      sol_q       <= '0;
      sol_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      pin_en_q    <= pin_en_d;
      pin_val_q   <= pin_val_d;
      sol_q       <= sol_d;
      sol_valid_q <= sol_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SEARCH;
      SEARCH: begin
        if (abort_i)        state_d = IDLE;
        else if (cand_ok)   state_d = FOUND;
        else if (last_cand) state_d = IDLE;
      end
      FOUND: begin
        if (abort_i)        state_d = IDLE;
        else if (handshake) state_d = last_cand ? IDLE : SEARCH;
      end
      default:              state_d = IDLE;
    endcase
  end

  always_comb begin
    cand_d      = cand_q;
    pin_en_d    = pin_en_q;
    pin_val_d   = pin_val_q;
    sol_d       = sol_q;
    sol_valid_d = sol_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cand_d    = '0;
          cnt_d     = '0;
          pin_en_d  = pin_en_i;
          pin_val_d = pin_val_i;
          busy_d    = 1'b1;
        end
      end
      SEARCH: begin
        if (abort_i) begin
          busy_d      = 1'b0;
          sol_valid_d = 1'b0;
        end else if (cand_ok) begin
          sol_d       = cand_q;
          sol_valid_d = 1'b1;
        end else if (last_cand) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      FOUND: begin
        // abort wins over a same-cycle handshake, so that solution is not counted
        if (abort_i) begin
          busy_d      = 1'b0;
          sol_valid_d = 1'b0;
        end else if (handshake) begin
          sol_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          if (last_cand) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end else begin
            cand_d = cand_q + 1'b1;
          end
        end
      end
      default: begin
        busy_d      = 1'b0;
        sol_valid_d = 1'b0;
      end
    endcase
  end

  assign busy_o      = busy_q;
  assign sol_valid_o = sol_valid_q;
  assign sol_o       = sol_q;
  assign done_o      = done_q;
  assign sol_cnt_o   = cnt_q;

endmodule
